// File: rtl/debug_unit.sv
// Host-side debug controller: decodes UART command bytes, loads instruction memory,
// runs or single-steps the pipeline, then dumps PC, registers and data memory to the host.
module debug_unit #(
    parameter int INST_SZ  = 32,
    parameter int PC_SZ    = 32,
    parameter int REG_SZ   = 5,
    parameter int READ_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    input  logic [PC_SZ-1:0]   i_pc,
    input  logic [INST_SZ-1:0] i_reg,
    input  logic [INST_SZ-1:0] i_mem,
    input  logic               i_halt,
    output logic               o_write,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_enable,
    output logic [REG_SZ-1:0]  o_debug_addr
);

    // TX handshake: o_tx_valid rises together with o_tx_data; both hold until an edge
    // with o_tx_valid=1 and i_tx_ready=1, after which the next byte may appear at once.
    localparam int SH_W       = 2 * INST_SZ;
    localparam int WORD_BYTES = INST_SZ / 8;
    localparam int PC_BYTES   = PC_SZ / 8;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] BYTE_ACK = 8'h06;
    localparam logic [7:0] BYTE_NAK = 8'h15;

    typedef enum logic [3:0] {
        IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, SCAN_PC, SCAN_WAIT, SCAN_TX, SEND_ACK
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic [2:0]         byte_idx, byte_idx_nxt;
    logic [INST_SZ-1:0] word, word_nxt;
    logic [SH_W-1:0]    shift, shift_nxt;
    logic [3:0]         rem, rem_nxt;
    logic [1:0]         wait_cnt, wait_cnt_nxt;
    logic [7:0]         tx_data_nxt;
    logic               tx_valid_nxt;
    logic               write_nxt;
    logic [INST_SZ-1:0] instruction_nxt;
    logic               enable_nxt;
    logic [REG_SZ-1:0]  debug_addr_nxt;
    logic [SH_W-1:0]    pc_aligned;
    logic               tx_fire;

    assign tx_fire    = o_tx_valid & i_tx_ready;
    assign pc_aligned = SH_W'(i_pc) << (SH_W - PC_SZ);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            cnt           <= '0;
            byte_idx      <= '0;
            word          <= '0;
            shift         <= '0;
            rem           <= '0;
            wait_cnt      <= '0;
            o_tx_data     <= '0;
            o_tx_valid    <= 1'b0;
            o_write       <= 1'b0;
            o_instruction <= '0;
            o_enable      <= 1'b0;
            o_debug_addr  <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            byte_idx      <= byte_idx_nxt;
            word          <= word_nxt;
            shift         <= shift_nxt;
            rem           <= rem_nxt;
            wait_cnt      <= wait_cnt_nxt;
            o_tx_data     <= tx_data_nxt;
            o_tx_valid    <= tx_valid_nxt;
            o_write       <= write_nxt;
            o_instruction <= instruction_nxt;
            o_enable      <= enable_nxt;
            o_debug_addr  <= debug_addr_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        byte_idx_nxt    = byte_idx;
        word_nxt        = word;
        shift_nxt       = shift;
        rem_nxt         = rem;
        wait_cnt_nxt    = wait_cnt;
        tx_data_nxt     = o_tx_data;
        tx_valid_nxt    = o_tx_valid;
        write_nxt       = 1'b0;
        instruction_nxt = o_instruction;
        enable_nxt      = 1'b0;
        debug_addr_nxt  = o_debug_addr;

        case (state)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: state_nxt = LD_CNT;
                        CMD_CONT: begin
                            if (i_halt) begin
                                state_nxt = SCAN_PC;
                            end else begin
                                state_nxt  = RUN;
                                enable_nxt = 1'b1;
                            end
                        end
                        CMD_STEP: begin
                            if (i_halt) begin
                                state_nxt = SCAN_PC;
                            end else begin
                                state_nxt  = STEP;
                                enable_nxt = 1'b1;
                            end
                        end
                        default: begin
                            state_nxt    = SEND_ACK;
                            tx_data_nxt  = BYTE_NAK;
                            tx_valid_nxt = 1'b1;
                        end
                    endcase
                end
            end
            LD_CNT: begin
                if (i_rx_valid) begin
                    cnt_nxt = i_rx_data;
                    if (i_rx_data == 8'd0) begin
                        state_nxt    = SEND_ACK;
                        tx_data_nxt  = BYTE_ACK;
                        tx_valid_nxt = 1'b1;
                    end else begin
                        state_nxt    = LD_BYTE;
                        byte_idx_nxt = '0;
                    end
                end
            end
            LD_BYTE: begin
                if (i_rx_valid) begin
                    word_nxt = {word[INST_SZ-9:0], i_rx_data};
                    if (byte_idx == 3'(WORD_BYTES - 1)) begin
                        state_nxt       = LD_WR;
                        write_nxt       = 1'b1;
                        instruction_nxt = word_nxt;
                    end else begin
                        byte_idx_nxt = byte_idx + 3'd1;
                    end
                end
            end
            LD_WR: begin
                cnt_nxt = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_nxt    = SEND_ACK;
                    tx_data_nxt  = BYTE_ACK;
                    tx_valid_nxt = 1'b1;
                end else begin
                    state_nxt    = LD_BYTE;
                    byte_idx_nxt = '0;
                end
            end
            RUN: begin
                // The halt edge itself still sees one enabled cycle; enable drops after it.
                if (i_halt) begin
                    state_nxt = SCAN_PC;
                end else begin
                    enable_nxt = 1'b1;
                end
            end
            STEP: state_nxt = SCAN_PC;
            SCAN_PC: begin
                if (!o_tx_valid) begin
                    tx_data_nxt  = pc_aligned[SH_W-1 -: 8];
                    shift_nxt    = pc_aligned << 8;
                    rem_nxt      = 4'(PC_BYTES - 1);
                    tx_valid_nxt = 1'b1;
                end else if (tx_fire) begin
                    if (rem == 4'd0) begin
                        tx_valid_nxt   = 1'b0;
                        debug_addr_nxt = '0;
                        wait_cnt_nxt   = '0;
                        state_nxt      = SCAN_WAIT;
                    end else begin
                        tx_data_nxt = shift[SH_W-1 -: 8];
                        shift_nxt   = shift << 8;
                        rem_nxt     = rem - 4'd1;
                    end
                end
            end
            SCAN_WAIT: begin
                if (wait_cnt == 2'(READ_LAT)) begin
                    shift_nxt = {i_reg, i_mem};
                    rem_nxt   = 4'(SH_W / 8);
                    state_nxt = SCAN_TX;
                end else begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            SCAN_TX: begin
                // rem counts bytes still to present after the one currently on o_tx_data.
                if (!o_tx_valid) begin
                    tx_data_nxt  = shift[SH_W-1 -: 8];
                    shift_nxt    = shift << 8;
                    rem_nxt      = rem - 4'd1;
                    tx_valid_nxt = 1'b1;
                end else if (tx_fire) begin
                    if (rem == 4'd0) begin
                        tx_valid_nxt = 1'b0;
                        if (o_debug_addr == {REG_SZ{1'b1}}) begin
                            debug_addr_nxt = '0;
                            state_nxt      = IDLE;
                        end else begin
                            debug_addr_nxt = o_debug_addr + 1'b1;
                            wait_cnt_nxt   = '0;
                            state_nxt      = SCAN_WAIT;
                        end
                    end else begin
                        tx_data_nxt = shift[SH_W-1 -: 8];
                        shift_nxt   = shift << 8;
                        rem_nxt     = rem - 4'd1;
                    end
                end
            end
            SEND_ACK: begin
                if (tx_fire) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: expected TX bytes and instruction writes are queued
// by the stimulus thread and checked by a negedge monitor as the DUT presents them.
module tb_debug_unit;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] i_pc;
    logic [31:0] i_reg;
    logic [31:0] i_mem;
    logic        i_halt;
    logic        o_write;
    logic [31:0] o_instruction;
    logic        o_enable;
    logic [4:0]  o_debug_addr;

    always #5 i_clk = ~i_clk;

    debug_unit #(.INST_SZ(32), .PC_SZ(32), .REG_SZ(5), .READ_LAT(1)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .i_pc(i_pc), .i_reg(i_reg), .i_mem(i_mem), .i_halt(i_halt),
        .o_write(o_write), .o_instruction(o_instruction),
        .o_enable(o_enable), .o_debug_addr(o_debug_addr)
    );

    // Register file / data memory model with one cycle of read latency.
    logic [31:0] regs [32];
    logic [31:0] mems [32];
    logic [31:0] reg_q = '0;
    logic [31:0] mem_q = '0;
    always @(posedge i_clk) begin
        reg_q <= regs[o_debug_addr];
        mem_q <= mems[o_debug_addr];
    end
    assign i_reg = reg_q;
    assign i_mem = mem_q;

    int tests_run    = 0;
    int tests_failed = 0;
    int en_cycles    = 0;
    int tx_idx       = 0;
    int ready_mode   = 0;
    int ready_cyc    = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] exp_w_q[$];
    logic        hold_prev = 1'b0;
    logic [7:0]  hold_data = '0;

    // TX ready driver: always ready, or ready one cycle in three.
    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            ready_cyc++;
            i_tx_ready = (ready_mode == 0) ? 1'b1 : ((ready_cyc % 3) == 0);
        end
    end

    // Monitor: checks handshake stability, TX bytes, write pulses, counts enable cycles.
    always @(negedge i_clk) begin
        logic [7:0]  e;
        logic [31:0] w;
        if (!i_reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                tests_run++;
                if (!o_tx_valid || o_tx_data !== hold_data) begin
                    tests_failed++;
                    $display("FAIL tx_stable: valid=%0b data=%02h, required valid=1 data=%02h",
                             o_tx_valid, o_tx_data, hold_data);
                end
            end
            if (o_tx_valid && i_tx_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL tx_unexpected: got byte %02h, none required", o_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_tx_data !== e) begin
                        tests_failed++;
                        $display("FAIL tx_byte[%0d]: got %02h, required %02h", tx_idx, o_tx_data, e);
                    end
                end
                tx_idx++;
            end
            hold_prev = o_tx_valid && !i_tx_ready;
            hold_data = o_tx_data;
            if (o_write) begin
                tests_run++;
                if (exp_w_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL write_unexpected: got %08h, none required", o_instruction);
                end else begin
                    w = exp_w_q.pop_front();
                    if (o_instruction !== w) begin
                        tests_failed++;
                        $display("FAIL write_word: got %08h, required %08h", o_instruction, w);
                    end
                end
            end
            if (o_enable) en_cycles++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tx_valid"}, 32'(o_tx_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
        check({tag, "_write"}, 32'(o_write), 32'd0);
        check({tag, "_instruction"}, o_instruction, 32'd0);
        check({tag, "_enable"}, 32'(o_enable), 32'd0);
        check({tag, "_debug_addr"}, 32'(o_debug_addr), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_clk);
        #1;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic push_word_bytes(input logic [31:0] v);
        for (int k = 3; k >= 0; k--) exp_q.push_back(v[k*8 +: 8]);
    endtask

    task automatic push_dump(input logic [31:0] pc);
        push_word_bytes(pc);
        for (int a = 0; a < 32; a++) begin
            push_word_bytes(regs[a]);
            push_word_bytes(mems[a]);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_w_q.size() != 0) && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        repeat (20) @(posedge i_clk);
        tests_run++;
        if (exp_q.size() != 0 || exp_w_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_timeout: %0d tx and %0d writes outstanding, required 0",
                     name, exp_q.size(), exp_w_q.size());
            exp_q.delete();
            exp_w_q.delete();
        end
    endtask

    task automatic load_simple_image();
        for (int a = 0; a < 32; a++) begin
            regs[a] = '0;
            mems[a] = '0;
        end
        regs[1] = 32'd5;
    endtask

    initial begin
        i_reset    = 1'b0;
        i_rx_data  = '0;
        i_rx_valid = 1'b0;
        i_pc       = '0;
        i_halt     = 1'b0;
        load_simple_image();
        repeat (3) @(posedge i_clk);
        #2;
        check_zero_outputs("reset_init");
        @(negedge i_clk);
        i_reset = 1'b1;

        // Two-word load.
        exp_w_q.push_back(32'h20010005);
        exp_w_q.push_back(32'hFC000000);
        exp_q.push_back(8'h06);
        en_cycles = 0;
        send_byte(8'h4C);
        send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hFC); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        drain("load2", 200);
        check("load2_enable_cycles", 32'(en_cycles), 32'd0);
        check("load2_instr_hold", o_instruction, 32'hFC000000);

        // Reset in the middle of a word, then a clean one-word load.
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge i_clk);
        i_reset = 1'b0;
        #2;
        check_zero_outputs("reset_mid_load");
        @(negedge i_clk);
        i_reset = 1'b1;
        exp_w_q.push_back(32'h12345678);
        exp_q.push_back(8'h06);
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        drain("load1", 200);

        // Single step and full dump.
        i_pc = 32'h00000004;
        load_simple_image();
        en_cycles = 0;
        tx_idx    = 0;
        push_dump(i_pc);
        send_byte(8'h53);
        drain("step_dump", 3000);
        check("step_enable_cycles", 32'(en_cycles), 32'd1);
        check("step_dump_bytes", 32'(tx_idx), 32'd260);
        check("step_addr_after", 32'(o_debug_addr), 32'd0);

        // Continuous run halted 20 cycles after the command.
        for (int a = 0; a < 32; a++) begin
            regs[a] = {8'(a), 8'hA5, ~8'(a), 8'(a * 3)};
            mems[a] = 32'hDEAD0000 | 32'(a * 7);
        end
        i_pc      = 32'h00400010;
        en_cycles = 0;
        tx_idx    = 0;
        push_dump(i_pc);
        send_byte(8'h43);
        repeat (20) @(posedge i_clk);
        #1;
        i_halt = 1'b1;
        drain("run_dump", 3000);
        check("run_enable_cycles", 32'(en_cycles), 32'd21);
        check("run_enable_after", 32'(o_enable), 32'd0);
        check("run_dump_bytes", 32'(tx_idx), 32'd260);

        // Continue while already halted: no enable, immediate dump.
        en_cycles = 0;
        push_dump(i_pc);
        send_byte(8'h43);
        drain("halted_dump", 3000);
        check("halted_enable_cycles", 32'(en_cycles), 32'd0);
        i_halt = 1'b0;

        // Step with backpressure: same byte sequence as the plain step.
        i_pc = 32'h00000004;
        load_simple_image();
        ready_mode = 1;
        en_cycles  = 0;
        tx_idx     = 0;
        push_dump(i_pc);
        send_byte(8'h53);
        drain("bp_dump", 6000);
        check("bp_enable_cycles", 32'(en_cycles), 32'd1);
        check("bp_dump_bytes", 32'(tx_idx), 32'd260);
        ready_mode = 0;

        // Unknown command NAK, then zero-count load proves IDLE was regained.
        exp_q.push_back(8'h15);
        send_byte(8'h7A);
        drain("nak", 100);
        exp_q.push_back(8'h06);
        send_byte(8'h4C);
        send_byte(8'h00);
        drain("load0", 100);

        // Bytes received during a dump must be dropped.
        push_dump(i_pc);
        send_byte(8'h53);
        repeat (10) @(posedge i_clk);
        send_byte(8'h4C);
        send_byte(8'h7A);
        send_byte(8'h43);
        drain("drop_dump", 3000);
        exp_q.push_back(8'h06);
        send_byte(8'h4C);
        send_byte(8'h00);
        drain("post_drop", 100);
        check("final_enable", 32'(o_enable), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
Host-side controller that drives the MIPS pipeline's debug/load interface from a byte stream (UART RX/TX side).
- Decodes host commands.
- Assembles 32-bit instruction words and writes them into instruction memory.
- Runs the pipeline continuously or one clock at a time.
- After a halt or step, scans PC, all registers and data memory words 0..31 back to the host as bytes.
- Sits between the UART and the pipeline top level.

Parameters:
INST_SZ, 32, data/instruction word width
PC_SZ, 32, PC width
REG_SZ, 5, debug address width (2^REG_SZ entries scanned)
READ_LAT, 1, cycles between o_debug_addr change and i_reg/i_mem valid (0..3)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  transmitter accepts byte
i_pc  in  PC_SZ  pipeline PC
i_reg  in  INST_SZ  register file word at o_debug_addr
i_mem  in  INST_SZ  data memory word at o_debug_addr
i_halt  in  1  pipeline halted
o_write  out  1  instruction memory write strobe
o_instruction  out  INST_SZ  instruction word to write
o_enable  out  1  pipeline execution enable
o_debug_addr  out  REG_SZ  register/memory debug address

Behaviour:
- Reset: the active-low reset is asynchronous. All outputs go to 0 and the FSM goes to IDLE; any partial word, count or scan is discarded.
- All outputs are registered.
- States: IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, SCAN_PC, SCAN_WAIT, SCAN_TX, SEND_ACK.
- IDLE commands, accepted on i_rx_valid:
  - 0x4C 'L' -> LD_CNT.
  - 0x43 'C' -> RUN, or directly to SCAN_PC if i_halt=1.
  - 0x53 'S' -> STEP, or directly to SCAN_PC if i_halt=1.
  - Any other byte -> SEND_ACK with byte 0x15 (NAK).
- LD_CNT: the next byte N is the instruction count.
  - N=0 -> SEND_ACK 0x06.
  - Otherwise -> LD_BYTE.
- LD_BYTE: shifts 4 bytes into the word, MSB first. After the 4th byte -> LD_WR.
- LD_WR: lasts exactly one cycle. o_write=1 and o_instruction=the assembled word.
  - o_instruction holds its value until the next word.
  - Decrement the remaining count. If remaining is 0 -> SEND_ACK 0x06, else -> LD_BYTE.
- RUN: o_enable=1 from the cycle after the command byte is accepted.
  - On the first edge sampling i_halt=1, o_enable drops in the next cycle and the FSM goes to SCAN_PC.
  - At most one enabled cycle overlaps the halt cycle.
- STEP: o_enable=1 for exactly one cycle, then -> SCAN_PC.
- SCAN_PC: latch i_pc and send 4 bytes MSB first, then set o_debug_addr=0 and go to SCAN_WAIT.
- SCAN_WAIT: wait READ_LAT cycles. Then latch {i_reg, i_mem} into a 64-bit shift register and go to SCAN_TX.
- SCAN_TX: send 8 bytes (reg MSB first, then mem MSB first).
  - If o_debug_addr=2^REG_SZ-1: reset o_debug_addr to 0 and go to IDLE (no wrap rescan).
  - Otherwise increment o_debug_addr and go to SCAN_WAIT.
- A full dump is 4+8*2^REG_SZ bytes (260 for defaults).
- TX handshake:
  - o_tx_valid rises with o_tx_data.
  - Both hold stable until an edge where o_tx_valid=1 and i_tx_ready=1.
  - The next byte may be presented in the following cycle.
  - i_tx_ready with o_tx_valid=0 is ignored.
- SEND_ACK: sends one byte under the TX handshake, then -> IDLE.
- RX bytes arriving in any state other than IDLE, LD_CNT or LD_BYTE are dropped, with no queuing.
- o_enable is 0 in every state except RUN and STEP. o_write is 0 outside LD_WR.

Test Plan:
1. Reset low mid-LD_BYTE (2 of 4 bytes received) -> all outputs 0; a following 'L',0x01,12,34,56,78 yields one o_write pulse with o_instruction=0x12345678, then tx 0x06.
2. 'L',0x02 then 8 bytes 0x20,0x01,0x00,0x05,0xFC,0x00,0x00,0x00 -> o_write pulses with 0x20010005 then 0xFC000000, o_enable stays 0, ACK 0x06.
3. 'S' with i_pc=0x00000004, i_reg[1]=5, i_mem all 0, i_tx_ready always 1 -> o_enable high exactly 1 cycle; 260 bytes, first 4 = 00 00 00 04, bytes 12..15 = 00 00 00 05.
4. 'C', i_halt asserted 20 cycles later -> o_enable high ≤21 cycles then 0; dump follows; a second 'C' while i_halt=1 -> no o_enable, immediate dump.
5. i_tx_ready toggled 1-of-3 cycles during dump -> o_tx_data stable while o_tx_valid=1 and not ready; byte sequence identical to scenario 3.
6. Command 0x7A -> single tx byte 0x15, back to IDLE; RX bytes sent during a dump are ignored.
